uart_receiver: RTL and testbench
================================

# uart_receiver

UART receive path for the board-side serial link: it synchronizes the `uart_txd_in` line, recovers 8N1 frames by 16× oversampling against an internal baud tick, and queues the received bytes in a small first-word-fall-through FIFO. It is the receive-side counterpart of the existing button-triggered transmit path, and runs at 115200 baud from the 100 MHz system clock. Framing errors and FIFO overruns are reported as single-cycle pulses.

## Interface
- `DBIT`, 8, data bits per frame, LSB first.
- `SB_TICK`, 16, oversample ticks spanned by the stop bit (16 = 1 stop bit).
- `DVSR`, 54, clock cycles per oversample tick (100 MHz / (54·16) ≈ 115.7 kbaud).
- `FIFO_W`, 2, FIFO address width; depth = 2**FIFO_W = 4.
- `clk`  in  1  system clock, 100 MHz; the block has one clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, idle high; asynchronous to `clk`.
- `rd`  in  1  pop request; one byte per cycle while high and `rx_empty`=0.
- `r_data`  out  DBIT  FIFO head; valid while `rx_empty`=0; reset 0.
- `rx_empty`  out  1  FIFO empty; reset 1.
- `rx_full`  out  1  FIFO full; reset 0.
- `frame_err`  out  1  one-cycle pulse when a stop bit samples low; reset 0.
- `overrun`  out  1  one-cycle pulse when a good byte arrives while the FIFO is full; reset 0.

## Operation
- **Synchronizer:** 2-FF chain on `rx`, reset to 1. The FSM uses only the synchronized value `rxs` and its previous sample `rxs_d`, which also resets to 1.
- **Tick generator:** counter runs 0..DVSR-1 and wraps. `s_tick` is high for the one cycle in which the counter equals DVSR-1. The counter free-runs and is never resynchronized to frames.
- **FSM states:** IDLE, START, DATA, STOP. Registers: `s` (4 bits), `n` (log2 DBIT bits), shift register `b`. All are reset to IDLE and 0.
- **IDLE:** a falling edge (`rxs_d`=1, `rxs`=0) moves to START with `s`=0. A line that is held low (break) does not retrigger.
- **START:** on each `s_tick`, increment `s`. At `s`=7, check the line:
  - `rxs`=0: go to DATA with `s`=0, `n`=0.
  - `rxs`=1: this is a glitch; return to IDLE with no output.
- **DATA:** on each `s_tick`, at `s`=15 set `b` = {`rxs`, `b[DBIT-1:1]`}, `s`=0, `n`++. After the sample with `n`=DBIT-1, go to STOP. Otherwise `s`++.
- **STOP:** on each `s_tick`, at `s`=SB_TICK-1 sample the line, then go to IDLE:
  - `rxs`=1 and FIFO not full: push `b`.
  - `rxs`=1 and FIFO full: drop the byte and pulse `overrun`.
  - `rxs`=0: drop the byte and pulse `frame_err`.
- **FIFO:**
  - Push and pop in the same cycle while full: both take effect and occupancy is unchanged.
  - Push and pop in the same cycle while empty: the push takes effect and `rd` is ignored.
  - `rd` while empty: no effect; pointers do not move.
  - Pointers wrap modulo 2**FIFO_W.
- **Reset mid-frame:** asynchronously returns the FSM to IDLE, empties the FIFO and clears all pulses. The partially received frame is discarded. Bits that arrive after release are not decoded until the next falling edge.

## Timing
- Bit time = 16·DVSR = 864 cycles; one frame = 8640 cycles.
- Start-detect latency: 2 cycles (synchronizer) plus 1 cycle (edge register).
- Sample points fall at mid-bit: start bit at tick 8, then every 16 ticks.
- Push: on the `s_tick` edge that samples the stop bit, `rx_empty` falls and `r_data` is valid on the next cycle.
- Pop: `rd` high at clock edge k; `r_data` updates to the next entry, or `rx_empty` rises, after edge k.
- `frame_err` and `overrun` are asserted for exactly one cycle, coincident with the cycle the push would have occurred.
- `rx_full` and `rx_empty` are registered; neither contains a combinational path from `rd`.

## Structure
- **Package `uart_pkg`:** defaults for DBIT, SB_TICK, DVSR; state enum `rx_state_t` {IDLE, START, DATA, STOP}. This package is shared with the transmit path.
- **Sub-module `fifo_sync`:** parameterized width/depth, FWFT, with `wr`, `rd`, `w_data`, `r_data`, `empty`, `full`. It is instantiated once here and reusable as the transmit FIFO.
- **Top-level logic:** the synchronizer, tick counter and FSM live in `uart_receiver` itself.

## Test plan
- **Single byte:** drive frame 0x55 (start, 10101010 LSB-first, stop) at 864 cycles/bit.
  - `rx_empty` falls about 9.5 bit times after the start edge, with `r_data`=0x55.
  - One `rd` pulse sets `rx_empty`=1.
- **Glitch:** hold `rx` low for 200 cycles (< 8 ticks = 432 cycles), then high.
  - No push and no `frame_err`; the FSM is back in IDLE.
- **Framing error:** send 0xA5 with the stop bit held low, then release the line high.
  - `frame_err` pulses once; FIFO stays empty; no second error.
- **Overrun:** send 0x01..0x05 back-to-back with no `rd`.
  - `rx_full`=1 after the 4th byte; `overrun` pulses on the 5th.
  - Popping yields 0x01, 0x02, 0x03, 0x04, then `rx_empty`=1.
- **Loopback:** connect the team's UART transmit path (button-triggered, 10 bytes) to `rx` and pop each byte as it arrives.
  - All 10 bytes are received in order with no errors, within 100 bit times plus margin.
- **Reset mid-frame:** assert `reset_n`=0 during the DATA bits of 0x3C, release it, then send 0xC3.
  - Only 0xC3 is received; the outputs show their reset values while reset is asserted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame/baud defaults and the receive FSM state type.
package uart_pkg;

    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int DVSR_DEF    = 54;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with registered empty/full flags.
module fifo_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              do_rd;
    logic              do_wr;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign do_rd  = rd & ~empty;
    assign do_wr  = wr & (~full | do_rd);
    assign r_data = mem[rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (do_wr) begin
                mem[wptr] <= w_data;
            end
            case ({do_wr, do_rd})
                2'b10: begin
                    wptr  <= wptr + 1'b1;
                    empty <= 1'b0;
                    full  <= ((wptr + 1'b1) == rptr);
                end
                2'b01: begin
                    rptr  <= rptr + 1'b1;
                    full  <= 1'b0;
                    empty <= ((rptr + 1'b1) == wptr);
                end
                2'b11: begin
                    wptr <= wptr + 1'b1;
                    rptr <= rptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: rx synchronizer, free-running 16x baud tick, frame FSM, FWFT byte FIFO.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int DVSR    = DVSR_DEF,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            rd,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
    output logic            overrun
);

    localparam int NW = $clog2(DBIT);
    localparam int CW = $clog2(DVSR);

    logic            rx_meta;
    logic            rxs;
    logic            rxs_d;
    logic [CW-1:0]   tick_cnt;
    logic            s_tick;
    rx_state_t       state, state_next;
    logic [3:0]      s, s_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic            push;
    logic            ferr_next;
    logic            ovr_next;

    assign s_tick = (tick_cnt == CW'(DVSR - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            rxs_d     <= 1'b1;
            tick_cnt  <= '0;
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            b         <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rxs       <= rx_meta;
            rxs_d     <= rxs;
            tick_cnt  <= s_tick ? '0 : tick_cnt + 1'b1;
            state     <= state_next;
            s         <= s_next;
            n         <= n_next;
            b         <= b_next;
            frame_err <= ferr_next;
            overrun   <= ovr_next;
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        push       = 1'b0;
        ferr_next  = 1'b0;
        ovr_next   = 1'b0;
        case (state)
            IDLE: begin
                // Edge-triggered so a held-low (break) line cannot restart a frame.
                if (rxs_d && !rxs) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == 4'd7) begin
                        if (!rxs) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == 4'd15) begin
                        b_next = {rxs, b[DBIT-1:1]};
                        s_next = '0;
                        n_next = n + 1'b1;
                        if (n == NW'(DBIT - 1)) begin
                            state_next = STOP;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == 4'(SB_TICK - 1)) begin
                        state_next = IDLE;
                        if (!rxs) begin
                            ferr_next = 1'b1;
                        end else if (rx_full) begin
                            ovr_next = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    fifo_sync #(
        .DATA_W (DBIT),
        .ADDR_W (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (push),
        .rd      (rd),
        .w_data  (b),
        .r_data  (r_data),
        .empty   (rx_empty),
        .full    (rx_full)
    );

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver; a shortened baud divisor keeps whole-frame scenarios brief.
module tb_uart_receiver;

    localparam int TB_DVSR = 16;
    localparam int BIT     = 16 * TB_DVSR;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_mis = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;

    uart_receiver #(.DVSR(TB_DVSR)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .rd        (rd),
        .r_data    (r_data),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
    end

    task automatic wait_cycles(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] d, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            wait_cycles(BIT);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val);
        rx = 1'b0;
        wait_cycles(BIT);
        send_bits(d, 8);
        rx = stop_val;
        wait_cycles(BIT);
        rx = 1'b1;
    endtask

    task automatic pop_expect(input logic [7:0] exp, input string tag);
        n_cmp++;
        if (rx_empty !== 1'b0 || r_data !== exp) begin
            n_mis++;
            $display("FAIL %s: got empty=%b data=%h, expected empty=0 data=%h", tag, rx_empty, r_data, exp);
        end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        wait_cycles(3);
        n_cmp++;
        if ({r_data, rx_empty, rx_full, frame_err, overrun} !== {8'h00, 4'b1000}) begin
            n_mis++;
            $display("FAIL reset_values: got data=%h e=%b f=%b fe=%b ov=%b, expected 00 1 0 0 0",
                     r_data, rx_empty, rx_full, frame_err, overrun);
        end
        reset_n = 1'b1;
        wait_cycles(BIT);
    endtask

    task automatic test_single_byte;
        rx = 1'b0;
        wait_cycles(BIT);
        send_bits(8'h55, 8);
        rx = 1'b1;
        wait_cycles(BIT / 4);
        n_cmp++;
        if (rx_empty !== 1'b1) begin
            n_mis++;
            $display("FAIL early_push: got rx_empty=%b before stop midpoint, expected 1", rx_empty);
        end
        wait_cycles(BIT - BIT / 4);
        pop_expect(8'h55, "single_byte");
        n_cmp++;
        if (rx_empty !== 1'b1) begin
            n_mis++;
            $display("FAIL single_pop_empty: got rx_empty=%b, expected 1", rx_empty);
        end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        n_cmp++;
        if (rx_empty !== 1'b1 || rx_full !== 1'b0) begin
            n_mis++;
            $display("FAIL rd_on_empty: got empty=%b full=%b, expected 1 0", rx_empty, rx_full);
        end
    endtask

    task automatic test_glitch;
        int fe0;
        fe0 = ferr_cnt;
        rx = 1'b0;
        wait_cycles(BIT / 4);
        rx = 1'b1;
        wait_cycles(2 * BIT);
        n_cmp++;
        if (rx_empty !== 1'b1 || ferr_cnt !== fe0) begin
            n_mis++;
            $display("FAIL glitch: got empty=%b ferr_delta=%0d, expected 1 0", rx_empty, ferr_cnt - fe0);
        end
        send_frame(8'h96, 1'b1);
        wait_cycles(4);
        pop_expect(8'h96, "after_glitch");
    endtask

    task automatic test_frame_error;
        int fe0;
        fe0 = ferr_cnt;
        rx = 1'b0;
        wait_cycles(BIT);
        send_bits(8'hA5, 8);
        rx = 1'b0;
        wait_cycles(2 * BIT);
        rx = 1'b1;
        wait_cycles(2 * BIT);
        n_cmp++;
        if (ferr_cnt - fe0 !== 1) begin
            n_mis++;
            $display("FAIL frame_err_count: got %0d pulse cycles, expected 1", ferr_cnt - fe0);
        end
        n_cmp++;
        if (rx_empty !== 1'b1) begin
            n_mis++;
            $display("FAIL frame_err_fifo: got rx_empty=%b, expected 1", rx_empty);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] v;
        int ov0;
        ov0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) begin
            v = 8'(i);
            send_frame(v, 1'b1);
        end
        n_cmp++;
        if (rx_full !== 1'b1 || ovr_cnt !== ov0) begin
            n_mis++;
            $display("FAIL full_after_4: got full=%b ovr_delta=%0d, expected 1 0", rx_full, ovr_cnt - ov0);
        end
        send_frame(8'h05, 1'b1);
        wait_cycles(4);
        n_cmp++;
        if (ovr_cnt - ov0 !== 1 || rx_full !== 1'b1) begin
            n_mis++;
            $display("FAIL overrun_pulse: got ovr_delta=%0d full=%b, expected 1 1", ovr_cnt - ov0, rx_full);
        end
        for (int i = 1; i <= 4; i++) begin
            v = 8'(i);
            pop_expect(v, "overrun_pop");
        end
        n_cmp++;
        if (rx_empty !== 1'b1 || rx_full !== 1'b0) begin
            n_mis++;
            $display("FAIL overrun_drain: got empty=%b full=%b, expected 1 0", rx_empty, rx_full);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] msg [10];
        int fe0;
        int ov0;
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h0A};
        fe0 = ferr_cnt;
        ov0 = ovr_cnt;
        for (int i = 0; i < 10; i++) begin
            send_frame(msg[i], 1'b1);
            pop_expect(msg[i], "loopback");
        end
        n_cmp++;
        if (rx_empty !== 1'b1 || ferr_cnt !== fe0 || ovr_cnt !== ov0) begin
            n_mis++;
            $display("FAIL loopback_end: got empty=%b fe_delta=%0d ov_delta=%0d, expected 1 0 0",
                     rx_empty, ferr_cnt - fe0, ovr_cnt - ov0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int fe0;
        send_frame(8'h7E, 1'b1);
        rx = 1'b0;
        wait_cycles(BIT);
        send_bits(8'h3C, 3);
        reset_n = 1'b0;
        wait_cycles(BIT / 2);
        n_cmp++;
        if ({r_data, rx_empty, rx_full, frame_err, overrun} !== {8'h00, 4'b1000}) begin
            n_mis++;
            $display("FAIL mid_reset_values: got data=%h e=%b f=%b fe=%b ov=%b, expected 00 1 0 0 0",
                     r_data, rx_empty, rx_full, frame_err, overrun);
        end
        reset_n = 1'b1;
        rx = 1'b1;
        wait_cycles(2 * BIT);
        fe0 = ferr_cnt;
        n_cmp++;
        if (rx_empty !== 1'b1) begin
            n_mis++;
            $display("FAIL mid_reset_discard: got rx_empty=%b, expected 1", rx_empty);
        end
        send_frame(8'hC3, 1'b1);
        wait_cycles(4);
        pop_expect(8'hC3, "after_reset");
        n_cmp++;
        if (rx_empty !== 1'b1 || ferr_cnt !== fe0) begin
            n_mis++;
            $display("FAIL after_reset_only: got empty=%b fe_delta=%0d, expected 1 0", rx_empty, ferr_cnt - fe0);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
